// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite to APB3 bridge. It carries one AHB transfer at a time onto APB.
// The APB side is clocked by HCLK. Every output comes straight from a flop.
// Optional feature macro: APB_TIMEOUT_EN. When it is defined, an ACCESS phase
// that waits TIMEOUT_CYCLES cycles without PREADY ends with an AHB ERROR.
module ahb_to_apb_bridge #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [31:0]         hrdata_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                pwrite_q;
  logic [31:0]         pwdata_q;
  logic                acc;
  logic                timeout;

  // HSIZE, the upper address bits and HTRANS[0] have no effect on the bridge.
  logic unused_in;
  assign unused_in = ^{HSIZE, HADDR[31:ADDR_W], HTRANS[0]};

  // A transfer is accepted only when it is selected, NONSEQ/SEQ, and the bus is ready.
  assign acc = HSEL & HTRANS[1] & HREADY;

`ifdef APB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Fire when this wait cycle would bring the ACCESS wait count up to the limit.
  assign timeout = (state_q == S_ACCESS) && !PREADY &&
                   (({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT_CYCLES));

  // Counter is zero whenever ACCESS is entered; it counts the cycles with PREADY low.
  always_comb begin
    cnt_d = 8'd0;
    if (state_q == S_ACCESS && !PREADY) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Register for the ACCESS wait counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  // Next state. The registered AHB and APB controls are decoded from the
  // state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: state_d = acc ? S_LATCH : S_IDLE;
      S_LATCH:                state_d = S_SETUP;
      S_SETUP:                state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          state_d = PSLVERR ? S_ERR1 : S_DONE;
        end else if (timeout) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:                 state_d = S_ERR2;
      default:                state_d = S_IDLE;
    endcase

    hreadyout_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
  end

  // State register and registered handshake outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  // Take the address and direction from the accepted address phase. They
  // hold until the next accepted transfer, so they stay stable over SETUP
  // and ACCESS.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
    end else if (state_d == S_LATCH) begin
      paddr_q  <= HADDR[ADDR_W-1:0];
      pwrite_q <= HWRITE;
    end
  end

  // Write data is valid in the AHB data phase, which is the LATCH cycle.
  // Reads leave it untouched.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pwdata_q <= 32'd0;
    end else if (state_q == S_LATCH && pwrite_q) begin
      pwdata_q <= HWDATA;
    end
  end

  // Read data is captured only when a read completes successfully. It holds
  // its value at all other times.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_q <= 32'd0;
    end else if (state_q == S_ACCESS && PREADY && !PSLVERR && !pwrite_q) begin
      hrdata_q <= PRDATA;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed testbench for ahb_to_apb_bridge. Inputs change 1 ns after the
// rising edge, and outputs are sampled on the falling edge.
module tb_ahb_to_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_chk = 0;
  int n_err = 0;
  int lowcnt;

  ahb_to_apb_bridge #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'd0; HREADY = 1'b1; PRDATA = 32'd0;
    PREADY = 1'b1; PSLVERR = 1'b0;

    // Reset values
    cyc(); cyc();
    @(negedge HCLK);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp",     32'(HRESP),     32'd0);
    chk("rst_hrdata",    HRDATA,         32'd0);
    chk("rst_psel",      32'(PSEL),      32'd0);
    chk("rst_penable",   32'(PENABLE),   32'd0);
    chk("rst_pwrite",    32'(PWRITE),    32'd0);
    chk("rst_paddr",     32'(PADDR),     32'd0);
    chk("rst_pwdata",    PWDATA,         32'd0);
    cyc();
    HRESETn = 1'b1;
    cyc();

    // HSEL with a BUSY transfer, then NONSEQ without HSEL: neither is accepted
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h4000_0008;
    cyc();
    HSEL = 1'b0; HTRANS = 2'b10;
    @(negedge HCLK);
    chk("busy_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("busy_psel",      32'(PSEL),      32'd0);
    cyc();
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("nosel_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("nosel_paddr",     32'(PADDR),     32'd0);
    cyc();

    // Zero-wait write
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0010; HWRITE = 1'b1; PREADY = 1'b1;
    cyc();                                   // LATCH
    HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    chk("w_latch_hreadyout", 32'(HREADYOUT), 32'd0);
    chk("w_latch_psel",      32'(PSEL),      32'd0);
    cyc();                                   // SETUP
    HWDATA = 32'h0;
    @(negedge HCLK);
    chk("w_setup_psel",      32'(PSEL),      32'd1);
    chk("w_setup_penable",   32'(PENABLE),   32'd0);
    chk("w_setup_paddr",     32'(PADDR),     32'h0010);
    chk("w_setup_pwrite",    32'(PWRITE),    32'd1);
    chk("w_setup_pwdata",    PWDATA,         32'hDEAD_BEEF);
    chk("w_setup_hreadyout", 32'(HREADYOUT), 32'd0);
    cyc();                                   // ACCESS
    @(negedge HCLK);
    chk("w_access_penable",  32'(PENABLE),   32'd1);
    chk("w_access_pwdata",   PWDATA,         32'hDEAD_BEEF);
    chk("w_access_hreadyout",32'(HREADYOUT), 32'd0);
    cyc();                                   // DONE
    @(negedge HCLK);
    chk("w_done_hreadyout",  32'(HREADYOUT), 32'd1);
    chk("w_done_hresp",      32'(HRESP),     32'd0);
    chk("w_done_psel",       32'(PSEL),      32'd0);
    cyc();                                   // IDLE

    // Read with two APB wait states
    HTRANS = 2'b10; HADDR = 32'h4000_0024; HWRITE = 1'b0; PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    lowcnt = 0;
    cyc();                                   // LATCH
    HTRANS = 2'b00;
    @(negedge HCLK); if (!HREADYOUT) lowcnt++;
    cyc();                                   // SETUP
    @(negedge HCLK); if (!HREADYOUT) lowcnt++;
    chk("r_setup_pwrite", 32'(PWRITE), 32'd0);
    cyc();                                   // ACCESS 1
    @(negedge HCLK); if (!HREADYOUT) lowcnt++;
    chk("r_acc1_penable", 32'(PENABLE), 32'd1);
    cyc();                                   // ACCESS 2
    @(negedge HCLK); if (!HREADYOUT) lowcnt++;
    chk("r_acc2_hrdata_held", HRDATA, 32'd0);
    chk("r_acc2_paddr",       32'(PADDR), 32'h0024);
    cyc();                                   // ACCESS 3
    PREADY = 1'b1;
    @(negedge HCLK); if (!HREADYOUT) lowcnt++;
    cyc();                                   // DONE
    @(negedge HCLK);
    chk("r_done_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("r_done_hrdata",    HRDATA,         32'h1234_5678);
    chk("r_low_cycles",     32'(lowcnt),    32'd5);
    cyc();                                   // IDLE

    // Read ending with PSLVERR
    HTRANS = 2'b10; HADDR = 32'h4000_0030; HWRITE = 1'b0; PREADY = 1'b1;
    PSLVERR = 1'b1; PRDATA = 32'hAAAA_5555;
    cyc();                                   // LATCH
    HTRANS = 2'b00;
    cyc();                                   // SETUP
    cyc();                                   // ACCESS
    cyc();                                   // ERR1
    PSLVERR = 1'b0;
    @(negedge HCLK);
    chk("e_err1_hreadyout", 32'(HREADYOUT), 32'd0);
    chk("e_err1_hresp",     32'(HRESP),     32'd1);
    chk("e_err1_psel",      32'(PSEL),      32'd0);
    cyc();                                   // ERR2
    @(negedge HCLK);
    chk("e_err2_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("e_err2_hresp",     32'(HRESP),     32'd1);
    chk("e_err2_hrdata",    HRDATA,         32'h1234_5678);
    cyc();                                   // IDLE
    @(negedge HCLK);
    chk("e_idle_hresp",     32'(HRESP),     32'd0);

    // Back-to-back: a write, then a read presented in its DONE cycle
    HTRANS = 2'b10; HADDR = 32'h4000_0040; HWRITE = 1'b1; PREADY = 1'b1;
    cyc();                                   // LATCH
    HTRANS = 2'b00; HWDATA = 32'h1111_2222;
    cyc();                                   // SETUP
    HWDATA = 32'h0;
    cyc();                                   // ACCESS
    cyc();                                   // DONE
    HTRANS = 2'b10; HADDR = 32'h4000_0044; HWRITE = 1'b0; PRDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    chk("b2b_done_hreadyout", 32'(HREADYOUT), 32'd1);
    cyc();                                   // LATCH, entered straight from DONE
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("b2b_latch_hreadyout", 32'(HREADYOUT), 32'd0);
    cyc();                                   // SETUP
    @(negedge HCLK);
    chk("b2b_setup_psel",   32'(PSEL),   32'd1);
    chk("b2b_setup_paddr",  32'(PADDR),  32'h0044);
    chk("b2b_setup_pwrite", 32'(PWRITE), 32'd0);
    chk("b2b_setup_pwdata", PWDATA,      32'h1111_2222);
    cyc();                                   // ACCESS
    cyc();                                   // DONE
    @(negedge HCLK);
    chk("b2b_done_hrdata", HRDATA, 32'hCAFE_F00D);
    cyc();                                   // IDLE

    // Asynchronous reset asserted in the middle of ACCESS
    HTRANS = 2'b10; HADDR = 32'h4000_0050; HWRITE = 1'b0; PREADY = 1'b0;
    cyc();                                   // LATCH
    HTRANS = 2'b00;
    cyc();                                   // SETUP
    cyc();                                   // ACCESS
    #1;
    HRESETn = 1'b0;
    #1;
    chk("ar_psel",      32'(PSEL),      32'd0);
    chk("ar_penable",   32'(PENABLE),   32'd0);
    chk("ar_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("ar_hrdata",    HRDATA,         32'd0);
    cyc();
    HRESETn = 1'b1; PREADY = 1'b1;
    cyc();
    @(negedge HCLK);
    chk("ar_idle_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("ar_idle_psel",      32'(PSEL),      32'd0);

`ifdef APB_TIMEOUT_EN
    // ACCESS timeout with PREADY held low
    cyc();
    HTRANS = 2'b10; HADDR = 32'h4000_0060; HWRITE = 1'b0; PREADY = 1'b0;
    cyc();                                   // LATCH
    HTRANS = 2'b00;
    cyc();                                   // SETUP
    for (int i = 0; i < 4; i++) begin
      cyc();                                 // ACCESS cycles 1..4
      @(negedge HCLK);
      chk("to_access_psel", 32'(PSEL), 32'd1);
    end
    cyc();                                   // ERR1
    @(negedge HCLK);
    chk("to_err1_psel",      32'(PSEL),      32'd0);
    chk("to_err1_hreadyout", 32'(HREADYOUT), 32'd0);
    chk("to_err1_hresp",     32'(HRESP),     32'd1);
    cyc();                                   // ERR2
    @(negedge HCLK);
    chk("to_err2_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("to_err2_hresp",     32'(HRESP),     32'd1);
    PREADY = 1'b1;
`else
    // Without the timeout feature, ACCESS waits indefinitely for PREADY
    cyc();
    HTRANS = 2'b10; HADDR = 32'h4000_0060; HWRITE = 1'b0; PREADY = 1'b0;
    PRDATA = 32'h0BAD_F00D;
    cyc();                                   // LATCH
    HTRANS = 2'b00;
    cyc();                                   // SETUP
    repeat (100) cyc();                      // ACCESS for 100 cycles
    @(negedge HCLK);
    chk("nto_psel",      32'(PSEL),      32'd1);
    chk("nto_penable",   32'(PENABLE),   32'd1);
    chk("nto_hreadyout", 32'(HREADYOUT), 32'd0);
    PREADY = 1'b1;
    cyc();                                   // DONE
    @(negedge HCLK);
    chk("nto_done_hrdata", HRDATA, 32'h0BAD_F00D);
`endif

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
